// File: rtl/ps2_keycode_decoder.sv
// PS/2 set-2 scancode decoder: prefix FSM, modifier tracking, US shift mapping,
// and a first-word-fall-through event queue for the CPU I/O port.
module ps2_keycode_decoder #(
    parameter int FIFO_DEPTH   = 8,
    parameter bit BREAK_EVENTS = 1'b1,
    parameter bit SHIFT_MAP_EN = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        new_in,
    input  logic [7:0]                  in,
    input  logic                        rd_en,
    input  logic                        clr_overflow,
    output logic [9:0]                  out,
    output logic                        valid,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic [3:0]                  modifiers,
    output logic                        overflow,
    output logic                        jmpff00
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;
    typedef struct packed {
        logic       released;
        logic       extended;
        logic [7:0] code;
    } event_t;

    // Returns {known, code}; every mapped code is non-zero.
    function automatic logic [8:0] base_lookup(input logic [7:0] sc);
        logic [7:0] c;
        c = 8'd0;
        case (sc)
            8'h1C: c = "a"; 8'h32: c = "b"; 8'h21: c = "c"; 8'h23: c = "d";
            8'h24: c = "e"; 8'h2B: c = "f"; 8'h34: c = "g"; 8'h33: c = "h";
            8'h43: c = "i"; 8'h3B: c = "j"; 8'h42: c = "k"; 8'h4B: c = "l";
            8'h3A: c = "m"; 8'h31: c = "n"; 8'h44: c = "o"; 8'h4D: c = "p";
            8'h15: c = "q"; 8'h2D: c = "r"; 8'h1B: c = "s"; 8'h2C: c = "t";
            8'h3C: c = "u"; 8'h2A: c = "v"; 8'h1D: c = "w"; 8'h22: c = "x";
            8'h35: c = "y"; 8'h1A: c = "z";
            8'h16: c = "1"; 8'h1E: c = "2"; 8'h26: c = "3"; 8'h25: c = "4";
            8'h2E: c = "5"; 8'h36: c = "6"; 8'h3D: c = "7"; 8'h3E: c = "8";
            8'h46: c = "9"; 8'h45: c = "0";
            8'h0E: c = 8'h60; 8'h4E: c = "-"; 8'h55: c = "="; 8'h54: c = "[";
            8'h5B: c = "]"; 8'h5D: c = "\\"; 8'h4C: c = ";"; 8'h52: c = "'";
            8'h41: c = ","; 8'h49: c = "."; 8'h4A: c = "/"; 8'h29: c = " ";
            8'h76: c = 8'd27; 8'h66: c = 8'd8;  8'h0D: c = 8'd9;  8'h5A: c = 8'd10;
            8'h05: c = 8'd11; 8'h06: c = 8'd12; 8'h04: c = 8'd13; 8'h0C: c = 8'd14;
            8'h03: c = 8'd15; 8'h0B: c = 8'd19; 8'h83: c = 8'd20; 8'h0A: c = 8'd21;
            8'h01: c = 8'd22; 8'h09: c = 8'd23; 8'h78: c = 8'd24; 8'h07: c = 8'd25;
            8'h6B: c = 8'd28; 8'h75: c = 8'd29; 8'h74: c = 8'd30; 8'h72: c = 8'd31;
            8'h6C: c = 8'd36; 8'h69: c = 8'd35; 8'h7D: c = 8'd33; 8'h7A: c = 8'd34;
            8'h70: c = 8'd45; 8'h71: c = 8'd46;
            8'h12: c = 8'd16; 8'h59: c = 8'd16; 8'h14: c = 8'd17; 8'h11: c = 8'd18;
            8'h58: c = 8'd20;
            default: c = 8'd0;
        endcase
        return {c != 8'd0, c};
    endfunction

    function automatic logic [7:0] shift_glyph(input logic [7:0] c);
        case (c)
            "1": return "!"; "2": return "@"; "3": return "#"; "4": return "$";
            "5": return "%"; "6": return "^"; "7": return "&"; "8": return "*";
            "9": return "("; "0": return ")"; "-": return "_"; "=": return "+";
            "[": return "{"; "]": return "}"; "\\": return "|"; ";": return ":";
            "'": return "\""; ",": return "<"; ".": return ">"; "/": return "?";
            8'h60: return "~";
            default: return c;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [2:0]      skip_q, skip_d;
    logic            prev_q, jmp_q, jmp_d;
    logic            shl_q, shl_d, shr_q, shr_d, ctrl_q, ctrl_d, alt_q, alt_d;
    logic            caps_q, caps_d, caps_held_q, caps_held_d;
    logic            overflow_q, overflow_d;
    logic            accept, key, key_rel, key_ext, push, pop, full, do_push, drop;
    logic [8:0]      hit;
    logic [7:0]      glyph;
    event_t          ev;
    event_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q;

    assign accept = new_in & ~prev_q;

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        jmp_d   = 1'b0;
        key     = 1'b0;
        key_rel = 1'b0;
        key_ext = 1'b0;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (in == 8'hE0)      state_d = EXT;
                    else if (in == 8'hF0) state_d = BRK;
                    else if (in == 8'hE1) begin
                        state_d = PAUSE;
                        jmp_d   = 1'b1;
                        skip_d  = 3'd7;
                    end else key = 1'b1;
                end
                EXT: begin
                    if (in == 8'hF0) state_d = EXT_BRK;
                    else begin
                        key     = 1'b1;
                        key_ext = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    key     = 1'b1;
                    key_rel = 1'b1;
                    state_d = IDLE;
                end
                EXT_BRK: begin
                    key     = 1'b1;
                    key_rel = 1'b1;
                    key_ext = 1'b1;
                    state_d = IDLE;
                end
                PAUSE: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Translation uses modifier state as it stood before this byte.
    always_comb begin
        shl_d       = shl_q;
        shr_d       = shr_q;
        ctrl_d      = ctrl_q;
        alt_d       = alt_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        push        = 1'b0;
        hit         = base_lookup(in);
        glyph       = hit[7:0];
        if (SHIFT_MAP_EN) begin
            if (glyph >= "a" && glyph <= "z" && ((shl_q | shr_q) ^ caps_q))
                glyph = glyph - 8'd32;
            else if (shl_q | shr_q)
                glyph = shift_glyph(glyph);
        end
        ev = '{released: key_rel, extended: key_ext, code: glyph};
        // E0 12 / E0 59 are the keyboard's fake shifts around extended keys.
        if (key && !(key_ext && (in == 8'h12 || in == 8'h59))) begin
            case (in)
                8'h12: shl_d  = ~key_rel;
                8'h59: shr_d  = ~key_rel;
                8'h14: ctrl_d = ~key_rel;
                8'h11: alt_d  = ~key_rel;
                8'h58: begin
                    caps_held_d = ~key_rel;
                    if (!key_rel && !caps_held_q) caps_d = ~caps_q;
                end
                default: ;
            endcase
            push = hit[8] & (~key_rel | BREAK_EVENTS);
        end
    end

    assign full       = (count_q == FULL_CNT);
    assign pop        = rd_en & (count_q != '0);
    assign do_push    = push & (~full | pop);
    assign drop       = push & full & ~pop;
    assign overflow_d = (overflow_q & ~clr_overflow) | drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            skip_q      <= '0;
            prev_q      <= 1'b0;
            jmp_q       <= 1'b0;
            shl_q       <= 1'b0;
            shr_q       <= 1'b0;
            ctrl_q      <= 1'b0;
            alt_q       <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            overflow_q  <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            prev_q      <= new_in;
            jmp_q       <= jmp_d;
            shl_q       <= shl_d;
            shr_q       <= shr_d;
            ctrl_q      <= ctrl_d;
            alt_q       <= alt_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            overflow_q  <= overflow_d;
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            count_q     <= count_q + CW'(do_push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= ev;
    end

    assign valid     = (count_q != '0);
    assign out       = valid ? mem[rptr_q] : 10'd0;
    assign count     = count_q;
    assign modifiers = {caps_q, alt_q, ctrl_q, shl_q | shr_q};
    assign overflow  = overflow_q;
    assign jmpff00   = jmp_q;
endmodule
